// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register with redirect path, combinational imem interface,
// and a FQ_DEPTH-entry queue presenting {pc, instr} to decode over valid/ready.
module fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FQ_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect_valid,
    input  logic [DATA_WIDTH-1:0]       redirect_target,
    output logic [DATA_WIDTH-1:0]       imem_addr,
    input  logic [DATA_WIDTH-1:0]       imem_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_instr,
    output logic [DATA_WIDTH-1:0]       out_pc,
    output logic [DATA_WIDTH-1:0]       out_pc_plus4,
    output logic [$clog2(FQ_DEPTH):0]   fq_count,
    output logic                        misaligned_err
);

    localparam int unsigned           PTR_W    = $clog2(FQ_DEPTH);
    localparam int unsigned           CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FQ_DEPTH);
    localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fq_entry_t;

    fq_entry_t fq_mem [FQ_DEPTH];

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  err_q, err_d;
    logic                  pop, push;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready & ~redirect_valid;
    assign push      = ~redirect_valid & ((count_q != FULL_CNT) | pop);
    assign err_d     = err_q | (redirect_valid & (|redirect_target[1:0]));

    // A redirect wins over fetch progress: flush everything and restart at the aligned target.
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_target[DATA_WIDTH-1:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                pc_d     = pc_q + PC_STEP;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // NOTE: queue storage is deliberately not reset; out_valid gates its contents via the count.
    always_ff @(posedge clk) begin
        if (push) begin
            fq_mem[wr_ptr_q] <= '{pc: pc_q, instr: imem_rdata};
        end
    end

    assign imem_addr      = pc_q;
    assign out_instr      = fq_mem[rd_ptr_q].instr;
    assign out_pc         = fq_mem[rd_ptr_q].pc;
    assign out_pc_plus4   = fq_mem[rd_ptr_q].pc + PC_STEP;
    assign fq_count       = count_q;
    assign misaligned_err = err_q;

endmodule
